// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared opcode/condition constants, flag bit positions and the EX control bundle.
// CTRL_EXEC_EN: when defined opcode 15 is a real EXEC, otherwise an illegal NOP.
package pipe_ctrl_unit_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_LHB  = 4'd10;
    localparam logic [3:0] OP_LLB  = 4'd11;
    localparam logic [3:0] OP_BR   = 4'd12;
    localparam logic [3:0] OP_JAL  = 4'd13;
    localparam logic [3:0] OP_JR   = 4'd14;
    localparam logic [3:0] OP_EXEC = 4'd15;

    localparam logic [2:0] COND_EQ = 3'd0;
    localparam logic [2:0] COND_NE = 3'd1;
    localparam logic [2:0] COND_GT = 3'd2;
    localparam logic [2:0] COND_LT = 3'd3;
    localparam logic [2:0] COND_GE = 3'd4;
    localparam logic [2:0] COND_LE = 3'd5;
    localparam logic [2:0] COND_OV = 3'd6;
    localparam logic [2:0] COND_AL = 3'd7;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

`ifdef CTRL_EXEC_EN
    localparam bit EXEC_EN = 1'b1;
`else
    localparam bit EXEC_EN = 1'b0;
`endif

    typedef enum logic {ST_IDLE, ST_STALL} stall_state_t;

    typedef struct packed {
        logic       valid;
        logic       dmem_wen;
        logic       rf_wen;
        logic [2:0] alu_op;
        logic       alusrc;
        logic       regdest;
        logic       mem2reg;
        logic       lhb_llb;
        logic       jal;
        logic       jr;
        logic       exec;
        logic       sets_flags;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_RST = '{valid: 1'b0, dmem_wen: 1'b1, rf_wen: 1'b0,
                                          alu_op: 3'd0, alusrc: 1'b0, regdest: 1'b0,
                                          mem2reg: 1'b0, lhb_llb: 1'b0, jal: 1'b0,
                                          jr: 1'b0, exec: 1'b0, sets_flags: 1'b0};

    function automatic ctrl_bundle_t decode_op(input logic [3:0] op);
        ctrl_bundle_t b;
        b = CTRL_RST;
        b.valid = 1'b1;
        if (!op[3]) begin
            b.alu_op     = op[2:0];
            b.rf_wen     = 1'b1;
            b.regdest    = 1'b1;
            b.alusrc     = op[2];
            b.sets_flags = !op[2];
        end else begin
            case (op)
                OP_LW: begin
                    b.alusrc  = 1'b1;
                    b.rf_wen  = 1'b1;
                    b.mem2reg = 1'b1;
                end
                OP_SW: begin
                    b.dmem_wen = 1'b0;
                    b.alusrc   = 1'b1;
                    b.lhb_llb  = 1'b1;
                end
                OP_LHB, OP_LLB: begin
                    b.rf_wen  = 1'b1;
                    b.lhb_llb = 1'b1;
                end
                OP_JAL: begin
                    b.rf_wen = 1'b1;
                    b.jal    = 1'b1;
                end
                OP_JR:   b.jr   = 1'b1;
                OP_EXEC: b.exec = EXEC_EN;
                default: ;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_cond.sv
// Branch condition evaluator: flag register + 4-bit condition field -> taken.
module ctrl_cond_eval
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int FLAG_W = 3
) (
    input  logic [FLAG_W-1:0] flags,
    input  logic [3:0]        cond,
    output logic              taken
);

    logic z, v, n, hit;

    always_comb begin
        z   = flags[FLAG_Z];
        v   = flags[FLAG_V];
        n   = flags[FLAG_N];
        hit = 1'b0;
        case (cond[2:0])
            COND_EQ: hit = z;
            COND_NE: hit = !z;
            COND_GT: hit = !z && !n;
            COND_LT: hit = n;
            COND_GE: hit = z || !n;
            COND_LE: hit = z || n;
            COND_OV: hit = v;
            COND_AL: hit = 1'b1;
            default: hit = 1'b1;
        endcase
        // bit 3 of the condition field marks a never-taken branch
        taken = hit && !cond[3];
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ID/EX control register with flag register, branch resolve and hazard stalls.
// Opcode 15 behaviour depends on CTRL_EXEC_EN (see pipe_ctrl_unit_pkg).
//   state    | meaning
//   ST_IDLE  | normal issue; load-use or flag hazard stalls combinationally
//   ST_STALL | extra load-use bubbles, cnt_q counts the ones still owed
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int LDUSE_STALL = 1,
    parameter int FLAG_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [3:0]        id_cond,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              stall_ext,
    input  logic [FLAG_W-1:0] flag_in,
    input  logic              flag_wen,
    output logic              id_stall,
    output logic              flush,
    output logic              br_taken,
    output logic              illegal_op,
    output logic              ex_valid,
    output logic              ex_dmem_wen,
    output logic              ex_rf_wen,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alusrc,
    output logic              ex_regdest,
    output logic              ex_mem2reg,
    output logic              ex_lhb_llb,
    output logic              ex_jal,
    output logic              ex_jr,
    output logic              ex_exec,
    output logic [REG_AW-1:0] ex_rd,
    output logic [FLAG_W-1:0] flags_q
);

    localparam logic [1:0] CNT_INIT = 2'(LDUSE_STALL - 1);

    ctrl_bundle_t      ex_q, id_bundle;
    logic [REG_AW-1:0] ex_rd_q;
    stall_state_t      state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              uses_rt, load_use, flag_haz, accept, cond_true, is_br;

    ctrl_cond_eval #(.FLAG_W(FLAG_W)) u_cond (
        .flags (flags_q),
        .cond  (id_cond),
        .taken (cond_true)
    );

    always_comb begin
        id_bundle = decode_op(id_opcode);
        is_br     = (id_opcode == OP_BR);
        uses_rt   = (id_opcode[3:2] == 2'b00) || (id_opcode == OP_SW);
        load_use  = ex_q.valid && ex_q.mem2reg &&
                    ((ex_rd_q == id_rs) || (uses_rt && (ex_rd_q == id_rt)));
        flag_haz  = is_br && ex_q.valid && ex_q.sets_flags;

        state_d  = state_q;
        cnt_d    = cnt_q;
        id_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_use) begin
                    id_stall = 1'b1;
                    if (LDUSE_STALL > 1) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end else if (flag_haz) begin
                    id_stall = 1'b1;
                end
            end
            ST_STALL: begin
                id_stall = 1'b1;
                cnt_d    = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        accept   = id_valid && !id_stall && !stall_ext;
        br_taken = accept && is_br && cond_true;
        flush    = br_taken ||
                   (accept && ((id_opcode == OP_JAL) || (id_opcode == OP_JR) ||
                               (EXEC_EN && (id_opcode == OP_EXEC))));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            flags_q    <= '0;
            ex_q       <= CTRL_RST;
            ex_rd_q    <= '0;
            illegal_op <= 1'b0;
        end else if (!stall_ext) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if (flag_wen) flags_q <= flag_in;
            ex_q       <= accept ? id_bundle : CTRL_RST;
            ex_rd_q    <= accept ? id_rd : '0;
            illegal_op <= accept && !EXEC_EN && (id_opcode == OP_EXEC);
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_dmem_wen = ex_q.dmem_wen;
    assign ex_rf_wen   = ex_q.rf_wen;
    assign ex_alu_op   = ex_q.alu_op;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_regdest  = ex_q.regdest;
    assign ex_mem2reg  = ex_q.mem2reg;
    assign ex_lhb_llb  = ex_q.lhb_llb;
    assign ex_jal      = ex_q.jal;
    assign ex_jr       = ex_q.jr;
    assign ex_exec     = EXEC_EN && ex_q.exec;
    assign ex_rd       = ex_rd_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Testbench for pipe_ctrl_unit: directed scenarios plus random traffic against a reference model.
module tb_pipe_ctrl_unit;

    localparam int LDUSE = 2;
`ifdef CTRL_EXEC_EN
    localparam bit EXEC_ON = 1'b1;
`else
    localparam bit EXEC_ON = 1'b0;
`endif
    // {valid, dmem_wen, rf_wen, alu_op[2:0], alusrc, regdest, mem2reg, lhb_llb, jal, jr, exec}
    localparam logic [12:0] RST_WORD = 13'h0800;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, stall_ext, flag_wen;
    logic [3:0] id_opcode, id_cond, id_rs, id_rt, id_rd;
    logic [2:0] flag_in;
    logic       id_stall, flush, br_taken, illegal_op;
    logic       ex_valid, ex_dmem_wen, ex_rf_wen, ex_alusrc, ex_regdest, ex_mem2reg;
    logic       ex_lhb_llb, ex_jal, ex_jr, ex_exec;
    logic [2:0] ex_alu_op;
    logic [3:0] ex_rd;
    logic [2:0] flags_q;
    logic [12:0] ex_word;

    int n_tests = 0;
    int n_fail  = 0;

    logic [12:0] m_word;
    int          m_op;
    logic [3:0]  m_rd;
    logic [2:0]  m_flags;
    logic        m_ill;
    int          m_left;
    logic        obs_stall, obs_flush, obs_br;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(4), .LDUSE_STALL(LDUSE), .FLAG_W(3)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_cond(id_cond),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .stall_ext(stall_ext),
        .flag_in(flag_in), .flag_wen(flag_wen), .id_stall(id_stall), .flush(flush),
        .br_taken(br_taken), .illegal_op(illegal_op), .ex_valid(ex_valid),
        .ex_dmem_wen(ex_dmem_wen), .ex_rf_wen(ex_rf_wen), .ex_alu_op(ex_alu_op),
        .ex_alusrc(ex_alusrc), .ex_regdest(ex_regdest), .ex_mem2reg(ex_mem2reg),
        .ex_lhb_llb(ex_lhb_llb), .ex_jal(ex_jal), .ex_jr(ex_jr), .ex_exec(ex_exec),
        .ex_rd(ex_rd), .flags_q(flags_q)
    );

    assign ex_word = {ex_valid, ex_dmem_wen, ex_rf_wen, ex_alu_op, ex_alusrc, ex_regdest,
                      ex_mem2reg, ex_lhb_llb, ex_jal, ex_jr, ex_exec};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] exp_word(input logic [3:0] op);
        logic [12:0] w;
        w = 13'h1800;
        if (op < 4'd8) begin
            w[10]  = 1'b1;
            w[9:7] = op[2:0];
            w[5]   = 1'b1;
            w[6]   = (op >= 4'd4);
        end else begin
            case (op)
                4'd8:         begin w[6] = 1'b1; w[10] = 1'b1; w[4] = 1'b1; end
                4'd9:         begin w[11] = 1'b0; w[6] = 1'b1; w[3] = 1'b1; end
                4'd10, 4'd11: begin w[10] = 1'b1; w[3] = 1'b1; end
                4'd13:        begin w[10] = 1'b1; w[2] = 1'b1; end
                4'd14:        w[1] = 1'b1;
                4'd15:        w[0] = EXEC_ON;
                default:      ;
            endcase
        end
        return w;
    endfunction

    function automatic bit cond_ok(input logic [3:0] c, input logic [2:0] f);
        bit z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        if (c[3]) return 1'b0;
        case (c[2:0])
            3'd0:    return z;
            3'd1:    return !z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return z || n;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_word  = RST_WORD;
        m_op    = 16;
        m_rd    = 4'd0;
        m_flags = 3'd0;
        m_ill   = 1'b0;
        m_left  = 0;
    endtask

    task automatic check_regs();
        check_val("ex_bundle", ex_word, m_word);
        check_val("ex_rd", ex_rd, m_rd);
        check_val("flags_q", flags_q, m_flags);
        check_val("illegal_op", illegal_op, m_ill);
    endtask

    task automatic cycle(input logic v, input logic [3:0] op, input logic [3:0] cnd,
                         input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                         input logic sx, input logic fw, input logic [2:0] fi);
        bit lu, fh, st, acc, tk, fl;
        @(negedge clk);
        check_regs();
        id_valid = v; id_opcode = op; id_cond = cnd;
        id_rs = rs; id_rt = rt; id_rd = rd;
        stall_ext = sx; flag_wen = fw; flag_in = fi;
        #1;
        lu  = m_word[12] && (m_op == 8) &&
              ((m_rd == rs) || (((op <= 4'd3) || (op == 4'd9)) && (m_rd == rt)));
        fh  = (op == 4'd12) && m_word[12] && (m_op <= 3);
        st  = (m_left > 0) || lu || fh;
        acc = v && !st && !sx;
        tk  = acc && (op == 4'd12) && cond_ok(cnd, m_flags);
        fl  = tk || (acc && ((op == 4'd13) || (op == 4'd14) || (EXEC_ON && (op == 4'd15))));
        obs_stall = id_stall;
        obs_flush = flush;
        obs_br    = br_taken;
        check_val("id_stall", id_stall, st);
        check_val("br_taken", br_taken, tk);
        check_val("flush", flush, fl);
        @(posedge clk);
        if (!sx) begin
            if (m_left > 0) m_left--;
            else if (lu) m_left = LDUSE - 1;
            m_word = acc ? exp_word(op) : RST_WORD;
            m_op   = acc ? int'(op) : 16;
            m_rd   = acc ? rd : 4'd0;
            m_ill  = acc && (op == 4'd15) && !EXEC_ON;
            if (fw) m_flags = fi;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_opcode = 4'd0; id_cond = 4'd0;
        id_rs = 4'd0; id_rt = 4'd0; id_rd = 4'd0;
        stall_ext = 1'b0; flag_wen = 1'b0; flag_in = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_regs();

        // reset in the middle of traffic with ADD in EX
        cycle(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'd7);
        cycle(1'b1, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 1'b0, 1'b0, 3'd0);
        check_val("pre_rst_valid", ex_valid, 1'b1);
        @(negedge clk);
        id_valid = 1'b0; flag_wen = 1'b0; stall_ext = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("rst_bundle", ex_word, RST_WORD);
        check_val("rst_rd", ex_rd, 4'd0);
        check_val("rst_flags", flags_q, 3'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // LW r3 then ADD r3: two stall cycles and two bubbles
        cycle(1'b1, 4'd8, 4'd0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd0, 4'd0, 4'd3, 4'd1, 4'd5, 1'b0, 1'b0, 3'd0);
            check_val("lu_stall", obs_stall, (i < 2));
            check_val("lu_ex_valid", ex_valid, (i == 2));
        end
        check_val("lu_alu_op", ex_alu_op, 3'd0);
        check_val("lu_rf_wen", ex_rf_wen, 1'b1);

        // SUB in EX then BR EQ with Z arriving: one stall, then taken
        cycle(1'b1, 4'd1, 4'd0, 4'd1, 4'd2, 4'd4, 1'b0, 1'b0, 3'd0);
        cycle(1'b1, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b100);
        check_val("fh_stall", obs_stall, 1'b1);
        check_val("fh_no_flush", obs_flush, 1'b0);
        cycle(1'b1, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
        check_val("fh_br_taken", obs_br, 1'b1);
        check_val("fh_flush", obs_flush, 1'b1);
        cycle(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
        check_val("fh_flush_once", obs_flush, 1'b0);

        // N=1, Z=0: GT not taken, LT taken, cond 8 never taken
        cycle(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 3'b001);
        cycle(1'b1, 4'd12, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
        check_val("br_gt", obs_br, 1'b0);
        cycle(1'b1, 4'd12, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
        check_val("br_lt", obs_br, 1'b1);
        cycle(1'b1, 4'd12, 4'd8, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
        check_val("br_never", obs_br, 1'b0);

        // JAL held in ID by stall_ext for three cycles
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'd13, 4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 3'd0);
            check_val("sx_flush", obs_flush, 1'b0);
            check_val("sx_hold", ex_word, exp_word(4'd12));
        end
        cycle(1'b1, 4'd13, 4'd0, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 3'd0);
        check_val("jal_flush", obs_flush, 1'b1);
        check_val("jal_ex", ex_jal, 1'b1);

        // opcode 15
        cycle(1'b1, 4'd15, 4'd0, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 3'd0);
        check_val("op15_flush", obs_flush, EXEC_ON);
        check_val("op15_exec", ex_exec, EXEC_ON);
        check_val("op15_rf_wen", ex_rf_wen, 1'b0);
        check_val("op15_illegal", illegal_op, !EXEC_ON);
        check_val("op15_valid", ex_valid, 1'b1);
        cycle(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0);
        check_val("op15_pulse", illegal_op, 1'b0);

        // random traffic with narrow register range to provoke hazards
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)));
        end
        @(negedge clk);
        check_regs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
